spmv_fp_row_accum: RTL and testbench

Parametrised floating-point row accumulator for the SpMV datapath. It sits directly after the multiplier. It consumes a stream of products, each tagged with an end-of-row flag, sums each row into an internal accumulator, and emits one row sum per row through a valid/ready output register. It generalises the fp16 adder to any exponent/mantissa width and adds streaming handshakes, row framing, leading-zero renormalisation, overflow saturation and status flags.

---
 rtl/spmv_fp_row_accum.sv | 128 ++++++++++++
 tb/tb_spmv_fp_row_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_fp_row_accum.sv
// Streaming floating-point row accumulator: sums each tagged row of products
// and emits one truncated row sum per row through a valid/ready output register.
module spmv_fp_row_accum #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int CNT_W = 16,
  localparam int FW = 1 + EXP_W + MAN_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [FW-1:0]    i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [FW-1:0]    o_data,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_row_cnt
);

  localparam int SW      = MAN_W + 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  // Handshake: a product moves on i_valid&i_ready, a row sum on o_valid&o_ready;
  // the output register may be refilled in the same cycle it is taken.
  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   acc_q, acc_d, acc_op;
  logic            accept;

  logic            a_s, b_s, l_s, s_s, b_big;
  logic [EXP_W-1:0] a_e, b_e, l_e, s_e, diff;
  logic [MAN_W-1:0] a_m, b_m, l_m, s_m, man_n;
  logic [SW-1:0]   sig_s;
  logic [SW:0]     sum;
  logic            a_zero, b_zero, a_inf, b_inf;
  int              lz, exp_adj;
  logic [FW-1:0]   add_res;
  logic            add_ovf;

  assign i_ready = ~o_valid | o_ready;
  assign accept  = i_valid & i_ready;

  assign {a_s, a_e, a_m} = acc_op;
  assign {b_s, b_e, b_m} = i_data;
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == '1);
  assign b_inf  = (b_e == '1);

  // Adder: i_data is the b operand so it wins a full magnitude tie.
  always_comb begin
    add_res = '0;
    add_ovf = 1'b0;
    b_big   = {b_e, b_m} >= {a_e, a_m};
    l_s     = b_big ? b_s : a_s;
    l_e     = b_big ? b_e : a_e;
    l_m     = b_big ? b_m : a_m;
    s_s     = b_big ? a_s : b_s;
    s_e     = b_big ? a_e : b_e;
    s_m     = b_big ? a_m : b_m;
    diff    = l_e - s_e;
    sig_s   = (int'(diff) >= MAN_W + 2) ? '0 : ({1'b1, s_m} >> diff);
    sum     = (l_s == s_s) ? ({1'b0, 1'b1, l_m} + {1'b0, sig_s})
                           : ({1'b0, 1'b1, l_m} - {1'b0, sig_s});
    lz = SW;
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lz = SW - 1 - i;
    end
    exp_adj = sum[SW] ? int'(l_e) + 1 : int'(l_e) - lz;
    man_n   = sum[SW] ? sum[SW-1:1] : MAN_W'(sum[SW-1:0] << lz);

    if (a_inf || b_inf) begin
      if (a_inf && b_inf) add_res = {(a_s == b_s) ? a_s : 1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else                add_res = {a_inf ? a_s : b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      add_res = '0;
    end else if (a_zero) begin
      add_res = i_data;
    end else if (b_zero) begin
      add_res = acc_op;
    end else if (sum == '0 || exp_adj <= 0) begin
      add_res = '0;
    end else if (exp_adj >= EXP_MAX) begin
      add_res = {l_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      add_ovf = 1'b1;
    end else begin
      add_res = {l_s, EXP_W'(exp_adj), man_n};
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = i_last ? IDLE : ACCUM;
  end

  // IDLE means no partial row, so the accumulator operand is forced to +0.
  always_comb begin
    acc_op = (state_q == IDLE) ? '0 : acc_q;
    acc_d  = acc_q;
    if (accept) acc_d = i_last ? '0 : add_res;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_ovf     <= 1'b0;
      o_row_cnt <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept && i_last) begin
        o_valid <= 1'b1;
        o_data  <= add_res;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
      if (accept && add_ovf) o_ovf <= 1'b1;
      if (o_valid && o_ready) o_row_cnt <= o_row_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spmv_fp_row_accum.sv
// Scoreboard bench for spmv_fp_row_accum (fp16): directed rows plus random rows
// checked against an integer-arithmetic reference of the truncating adder.
module tb_spmv_fp_row_accum;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic        i_last;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_ovf;
  logic [15:0] o_row_cnt;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [15:0] m_acc;
  bit          m_ovf;
  logic [15:0] m_takes;

  always #5 i_clk = ~i_clk;

  spmv_fp_row_accum #(.EXP_W(5), .MAN_W(10), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_ovf(o_ovf), .o_row_cnt(o_row_cnt)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: align with truncation, add as integers, renormalise by loops.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b, output bit ov);
    int ea, eb, ma, mb, el, es, ml, ms, sl_sig, ss_sig, mag, e;
    bit sa, sb, sl, ss;
    ov = 0;
    sa = a[15]; ea = a[14:10]; ma = a[9:0];
    sb = b[15]; eb = b[14:10]; mb = b[9:0];
    if (ea == 31 || eb == 31) begin
      if (ea == 31 && eb == 31) return {(sa == sb) ? sa : 1'b0, 5'h1f, 10'h0};
      return {(ea == 31) ? sa : sb, 5'h1f, 10'h0};
    end
    if (ea == 0 && eb == 0) return 16'h0;
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (eb > ea || (eb == ea && mb >= ma)) begin
      sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
    end else begin
      sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
    end
    sl_sig = 1024 + ml;
    ss_sig = (el - es >= 12) ? 0 : ((1024 + ms) >> (el - es));
    mag = (sl == ss) ? sl_sig + ss_sig : sl_sig - ss_sig;
    if (mag == 0) return 16'h0;
    e = el;
    while (mag >= 2048) begin mag = mag >> 1; e++; end
    while (mag < 1024) begin mag = mag << 1; e--; end
    if (e <= 0) return 16'h0;
    if (e >= 31) begin ov = 1; return {sl, 5'h1f, 10'h0}; end
    return {sl, 5'(e), 10'(mag)};
  endfunction

  function automatic void model_accept(input logic [15:0] d, input bit last);
    bit ov;
    logic [15:0] r;
    r = ref_add(m_acc, d, ov);
    if (ov) m_ovf = 1;
    if (last) begin
      exp_q.push_back({m_ovf, r});
      m_acc = 16'h0;
    end else begin
      m_acc = r;
    end
  endfunction

  // Monitor: every output handshake pops one expected row sum.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      exp_q.delete();
      m_takes = 16'h0;
    end else if (o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {16'h0, o_data}, 32'hffff_ffff);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("row_sum", {16'h0, o_data}, {16'h0, e[15:0]});
        check("row_ovf", {31'h0, o_ovf}, {31'h0, e[16]});
        check("row_cnt", {16'h0, o_row_cnt}, {16'h0, m_takes});
      end
      m_takes = m_takes + 16'h1;
    end
  end

  task automatic drive(input bit v, input logic [15:0] d, input bit l, input bit ordy, output bit acc);
    @(posedge i_clk);
    #2;
    i_valid = v; i_data = d; i_last = l; o_ready = ordy;
    @(negedge i_clk);
    acc = v && i_ready;
    if (acc) model_accept(d, l);
  endtask

  task automatic send(input logic [15:0] d, input bit l, input bit rnd_rdy);
    bit acc = 0;
    for (int n = 0; n < 40 && !acc; n++)
      drive(1'b1, d, l, rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
    if (!acc) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) drive(1'b0, 16'h0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #2;
    i_rstn = 1'b0; i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b1;
    @(posedge i_clk);
    #2;
    i_rstn = 1'b1;
    m_acc = 16'h0;
    m_ovf = 0;
  endtask

  function automatic logic [15:0] rnd_fp();
    case ($urandom_range(0, 15))
      0:       return {$urandom_range(0, 1) == 1, 5'h0, 10'($urandom)};
      1:       return {$urandom_range(0, 1) == 1, 5'd30, 10'($urandom)};
      2:       return ($urandom_range(0, 7) == 0) ? {$urandom_range(0, 1) == 1, 5'h1f, 10'h0}
                                                  : {1'b0, 5'd15, 10'h0};
      default: return {$urandom_range(0, 1) == 1, 5'($urandom_range(8, 22)), 10'($urandom)};
    endcase
  endfunction

  initial begin
    bit acc;
    logic [15:0] cnt0;
    i_rstn = 1'b0; i_valid = 1'b0; i_data = 16'h0; i_last = 1'b0; o_ready = 1'b1;
    m_acc = 16'h0; m_ovf = 0;

    do_reset();
    @(negedge i_clk);
    check("rst_o_valid", {31'h0, o_valid}, 32'h0);
    check("rst_o_data", {16'h0, o_data}, 32'h0);
    check("rst_o_ovf", {31'h0, o_ovf}, 32'h0);
    check("rst_row_cnt", {16'h0, o_row_cnt}, 32'h0);
    check("rst_i_ready", {31'h0, i_ready}, 32'h1);

    // 1.0 + 2.0 + 0.5 = 3.5, visible one cycle after the last accept
    send(16'h3C00, 0, 0); send(16'h4000, 0, 0); send(16'h3800, 1, 0);
    drive(1'b0, 16'h0, 1'b0, 1'b1, acc);
    check("lat_o_valid", {31'h0, o_valid}, 32'h1);
    check("lat_o_data", {16'h0, o_data}, 32'h4300);
    drive(1'b0, 16'h0, 1'b0, 1'b1, acc);
    check("pulse_fall", {31'h0, o_valid}, 32'h0);
    check("cnt_after_1", {16'h0, o_row_cnt}, 32'h1);

    send(16'h3E00, 0, 0); send(16'hBC00, 1, 0);
    send(16'h4000, 0, 0); send(16'hC000, 1, 0);
    send(16'h7BFF, 0, 0); send(16'h7BFF, 1, 0);
    send(16'h3C00, 1, 0);
    idle(2);
    check("ovf_sticky", {31'h0, o_ovf}, 32'h1);

    // Backpressure: sum held five cycles, then take and refill together
    cnt0 = o_row_cnt;
    drive(1'b1, 16'h3C00, 1'b1, 1'b0, acc);
    check("bp_first_accept", {31'h0, acc}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h4200, 1'b1, 1'b0, acc);
      check("bp_blocked", {31'h0, acc}, 32'h0);
      check("bp_hold_data", {16'h0, o_data}, 32'h3C00);
    end
    drive(1'b1, 16'h4200, 1'b1, 1'b1, acc);
    check("bp_take_accept", {31'h0, acc}, 32'h1);
    drive(1'b0, 16'h0, 1'b0, 1'b1, acc);
    check("bp_valid_kept", {31'h0, o_valid}, 32'h1);
    check("bp_new_data", {16'h0, o_data}, 32'h4200);
    check("bp_cnt", {16'h0, o_row_cnt}, {16'h0, cnt0 + 16'h1});
    idle(1);

    send(16'h0001, 0, 0); send(16'h3C00, 1, 0);
    send(16'h0000, 1, 0);
    idle(2);

    // Reset mid-row discards the partial 2.0
    send(16'h4000, 0, 0);
    do_reset();
    @(negedge i_clk);
    check("midrst_cnt", {16'h0, o_row_cnt}, 32'h0);
    check("midrst_ovf", {31'h0, o_ovf}, 32'h0);
    send(16'h3C00, 1, 0);
    idle(2);
    check("midrst_cnt_after", {16'h0, o_row_cnt}, 32'h1);

    for (int r = 0; r < 150; r++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send(rnd_fp(), k == len - 1, 1);
        if ($urandom_range(0, 4) == 0) drive(1'b0, 16'h0, 1'b0, $urandom_range(0, 1) == 1, acc);
      end
    end

    for (int n = 0; n < 50 && (exp_q.size() != 0 || o_valid); n++) idle(1);
    check("drain_queue_empty", exp_q.size(), 32'h0);
    check("drain_o_valid", {31'h0, o_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
